spi_frame_streamer: RTL and testbench

SPI_FRAME_STREAMER -- requirements
Module: spi_frame_streamer

---
 rtl/spi_frame_streamer_pkg.sv | 23 ++
 rtl/spi_frame_streamer_fifo.sv | 50 +++++
 rtl/spi_frame_streamer.sv | 192 +++++++++++++++++++
 tb/tb_spi_frame_streamer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_frame_streamer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_stream_pkg : serializer state encoding and parameter defaults    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package spi_stream_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int c_DEF_DATA_WIDTH      = 16;
    localparam int c_DEF_LINES           = 6;
    localparam int c_DEF_DATA_CLK_PERIOD = 6;
    localparam int c_DEF_DS_SHIFT        = 1;
    localparam int c_DEF_FIFO_DEPTH      = 4;
    localparam int c_DEF_HCOUNT_W        = 11;
    localparam int c_DEF_VCOUNT_W        = 10;

endpackage
`default_nettype wire

// File: rtl/spi_frame_streamer_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | packet_fifo : synchronous packet FIFO, same-cycle push/pop when full |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module packet_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             w_do_push;
    logic             w_do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign w_do_pop  = pop_i && !empty_o;
    assign w_do_push = push_i && (!full_o || w_do_pop);
    assign rdata_o   = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (w_do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (w_do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule
`default_nettype wire

// File: rtl/spi_frame_streamer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_frame_streamer : packs downsampled pixels into LINES-wide SPI     |
// | packets. Optional frame marker packet: SPI_FRAME_MARKER_EN. Rev 1.0  |
// +----------------------------------------------------------------------+
module spi_frame_streamer
    import spi_stream_pkg::*;
#(
    parameter int DATA_WIDTH      = c_DEF_DATA_WIDTH,
    parameter int LINES           = c_DEF_LINES,
    parameter int DATA_CLK_PERIOD = c_DEF_DATA_CLK_PERIOD,
    parameter int DS_SHIFT        = c_DEF_DS_SHIFT,
    parameter int FIFO_DEPTH      = c_DEF_FIFO_DEPTH,
    parameter int HCOUNT_W        = c_DEF_HCOUNT_W,
    parameter int VCOUNT_W        = c_DEF_VCOUNT_W
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  pixel_valid_in,
    input  logic [DATA_WIDTH-1:0] pixel_data_in,
    input  logic [HCOUNT_W-1:0]   hcount_in,
    input  logic [VCOUNT_W-1:0]   vcount_in,
    output logic [LINES-1:0]      chip_data_out,
    output logic                  chip_clk_out,
    output logic                  chip_sel_out,
    output logic                  busy_out,
    output logic                  overflow_out
);
    localparam int PKT_W  = LINES * DATA_WIDTH;
    localparam int CNT_W  = $clog2(DATA_CLK_PERIOD);
    localparam int BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int SLOT_W = (LINES > 1) ? $clog2(LINES) : 1;

    localparam logic [HCOUNT_W-1:0] H_MASK    = HCOUNT_W'((1 << DS_SHIFT) - 1);
    localparam logic [VCOUNT_W-1:0] V_MASK    = VCOUNT_W'((1 << DS_SHIFT) - 1);
    localparam logic [CNT_W-1:0]    CNT_HALF  = CNT_W'(DATA_CLK_PERIOD / 2 - 1);
    localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(DATA_CLK_PERIOD - 1);
    localparam logic [BIT_W-1:0]    BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
    localparam logic [SLOT_W-1:0]   SLOT_LAST = SLOT_W'(LINES - 1);

    logic              w_sel;
    logic              w_frame_start;
    logic [SLOT_W-1:0] w_slot;
    logic [SLOT_W-1:0] slot_cnt_q, slot_cnt_d;
    logic [PKT_W-1:0]  pkt_q, pkt_d;
    logic              w_push_data;
    logic              w_push;
    logic [PKT_W-1:0]  w_wdata;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic              w_drop;
    logic [PKT_W-1:0]  w_rdata;
    logic [LINES-1:0]  w_load_msb;
    logic [LINES-1:0]  w_next_msb;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [BIT_W-1:0]  bit_q;
    logic [PKT_W-1:0]  shift_q;
    logic [LINES-1:0]  data_q;
    logic              sclk_q;
    logic              cs_q;
    logic              ovf_q;

    assign w_sel         = pixel_valid_in && ((hcount_in & H_MASK) == '0) &&
                           ((vcount_in & V_MASK) == '0);
    assign w_frame_start = w_sel && (hcount_in == '0) && (vcount_in == '0);
    assign w_slot        = w_frame_start ? '0 : slot_cnt_q;
    assign w_push_data   = w_sel && (w_slot == SLOT_LAST);

    always_comb begin
        pkt_d      = pkt_q;
        slot_cnt_d = slot_cnt_q;
        if (w_sel) begin
            for (int s = 0; s < LINES; s++) begin
                if (w_slot == SLOT_W'(s)) pkt_d[s*DATA_WIDTH +: DATA_WIDTH] = pixel_data_in;
            end
            slot_cnt_d = w_push_data ? '0 : w_slot + 1'b1;
        end
    end

`ifdef SPI_FRAME_MARKER_EN
    assign w_push  = w_push_data || w_frame_start;
    assign w_wdata = w_frame_start ? '1 : pkt_d;
`else
    assign w_push  = w_push_data;
    assign w_wdata = pkt_d;
`endif

    assign w_pop  = !w_empty && ((state_q == IDLE) || ((state_q == GAP) && (cnt_q == CNT_LAST)));
    assign w_drop = w_push && w_full && !w_pop;

    packet_fifo #(
        .WIDTH (PKT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_in),
        .rst_i   (rst_in),
        .push_i  (w_push),
        .wdata_i (w_wdata),
        .pop_i   (w_pop),
        .rdata_o (w_rdata),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    // Shifting the whole packet left by one keeps every slot's next bit at its MSB.
    for (genvar i = 0; i < LINES; i++) begin : g_msb
        assign w_load_msb[i] = w_rdata[i*DATA_WIDTH + DATA_WIDTH - 1];
        assign w_next_msb[i] = shift_q[i*DATA_WIDTH + DATA_WIDTH - 2];
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            slot_cnt_q <= '0;
            pkt_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            slot_cnt_q <= slot_cnt_d;
            pkt_q      <= pkt_d;
            ovf_q      <= w_drop;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            sclk_q  <= 1'b0;
            cs_q    <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_pop) begin
                        state_q <= SEND;
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        shift_q <= w_rdata;
                        data_q  <= w_load_msb;
                        cs_q    <= 1'b0;
                        sclk_q  <= 1'b0;
                    end
                end
                SEND: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_HALF) sclk_q <= 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        cnt_q  <= '0;
                        sclk_q <= 1'b0;
                        if (bit_q == BIT_LAST) begin
                            state_q <= GAP;
                            cs_q    <= 1'b1;
                            data_q  <= '0;
                        end else begin
                            bit_q   <= bit_q + 1'b1;
                            shift_q <= shift_q << 1;
                            data_q  <= w_next_msb;
                        end
                    end
                end
                GAP: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        cnt_q <= '0;
                        if (w_pop) begin
                            state_q <= SEND;
                            bit_q   <= '0;
                            shift_q <= w_rdata;
                            data_q  <= w_load_msb;
                            cs_q    <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign chip_data_out = data_q;
    assign chip_clk_out  = sclk_q;
    assign chip_sel_out  = cs_q;
    assign overflow_out  = ovf_q;
    assign busy_out      = (state_q != IDLE) || !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_spi_frame_streamer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_spi_frame_streamer : packet-level reference model, per-cycle check |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_spi_frame_streamer;
    localparam int DW = 16, LN = 6, DCP = 6, DS = 1, FD = 4, HW = 11, VW = 10;
    localparam int PKT_CYC = (DW + 1) * DCP;

    typedef logic [LN-1:0][DW-1:0] pkt_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          pv  = 1'b0;
    logic [DW-1:0] pd  = '0;
    logic [HW-1:0] hc  = '0;
    logic [VW-1:0] vc  = '0;
    wire  [LN-1:0] cdata;
    wire           cclk, csel, busy, ovf;

    spi_frame_streamer #(
        .DATA_WIDTH(DW), .LINES(LN), .DATA_CLK_PERIOD(DCP), .DS_SHIFT(DS),
        .FIFO_DEPTH(FD), .HCOUNT_W(HW), .VCOUNT_W(VW)
    ) dut (
        .clk_in(clk), .rst_in(rst), .pixel_valid_in(pv), .pixel_data_in(pd),
        .hcount_in(hc), .vcount_in(vc), .chip_data_out(cdata), .chip_clk_out(cclk),
        .chip_sel_out(csel), .busy_out(busy), .overflow_out(ovf)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of pending packets plus the start edge of the current transfer.
    pkt_t    mq[$];
    pkt_t    cur, asm_p;
    int      slot = 0;
    bit      active = 0;
    longint  s_edge = 0, edge_n = 0;
    bit      chk_en = 0;
    bit      m_ovf;
    logic    exp_cs = 1, exp_ck = 0, exp_busy = 0, exp_ovf = 0;
    logic [LN-1:0] exp_data = '0;
    longint  k;
    int      b;

    function automatic bit model_push(input pkt_t p);
        if (mq.size() < FD) begin
            mq.push_back(p);
            return 1'b0;
        end
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        edge_n++;
        m_ovf = 1'b0;
        if (rst) begin
            chk_en = 1;
            mq.delete();
            slot   = 0;
            active = 0;
        end else begin
            if (active && (edge_n - s_edge >= PKT_CYC)) active = 0;
            if (!active && mq.size() > 0) begin
                cur    = mq.pop_front();
                active = 1;
                s_edge = edge_n;
            end
            if (pv && (hc % (1 << DS)) == 0 && (vc % (1 << DS)) == 0) begin
                if (hc == 0 && vc == 0) begin
                    slot = 0;
`ifdef SPI_FRAME_MARKER_EN
                    if (model_push('1)) m_ovf = 1'b1;
`endif
                end
                asm_p[slot] = pd;
                slot++;
                if (slot == LN) begin
                    slot = 0;
                    if (model_push(asm_p)) m_ovf = 1'b1;
                end
            end
        end
        exp_ovf  = m_ovf;
        exp_cs   = 1'b1;
        exp_ck   = 1'b0;
        exp_data = '0;
        if (active) begin
            k = edge_n - s_edge;
            if (k < DW * DCP) begin
                b      = int'(k / DCP);
                exp_cs = 1'b0;
                exp_ck = ((k % DCP) >= DCP / 2);
                for (int i = 0; i < LN; i++) exp_data[i] = cur[i][DW-1-b];
            end
        end
        exp_busy = active || (mq.size() > 0);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("chip_sel",  csel,  exp_cs);
            check("chip_clk",  cclk,  exp_ck);
            check("chip_data", cdata, exp_data);
            check("busy",      busy,  exp_busy);
            check("overflow",  ovf,   exp_ovf);
        end
    end

    // Bus monitor: rebuilds packets from the SPI pins for the scenario checks.
    pkt_t sh_p;
    pkt_t got_q[$];
    int   low_q[$];
    int   nbits = 0, cur_low = 0, ck_rises = 0, ovf_pulses = 0, busy_cycles = 0;
    logic prev_ck = 1'b0, prev_cs = 1'b1;

    always @(negedge clk) begin
        if (chk_en) begin
            if (!csel) cur_low++;
            if (cclk && !prev_ck) begin
                ck_rises++;
                for (int i = 0; i < LN; i++) sh_p[i] = {sh_p[i][DW-2:0], cdata[i]};
                nbits++;
            end
            if (csel && !prev_cs) begin
                if (nbits == DW) begin
                    got_q.push_back(sh_p);
                    low_q.push_back(cur_low);
                end
                nbits   = 0;
                cur_low = 0;
            end
            if (ovf)  ovf_pulses++;
            if (busy) busy_cycles++;
            prev_ck = cclk;
            prev_cs = csel;
        end
    end

    function automatic logic [DW-1:0] got_word(input int p, input int l);
        if (p < got_q.size()) return got_q[p][l];
        return 'x;
    endfunction

    task automatic clear_mon();
        got_q.delete();
        low_q.delete();
        ovf_pulses  = 0;
        busy_cycles = 0;
    endtask

    task automatic drive(input bit v, input logic [DW-1:0] d, input int h, input int vv);
        @(negedge clk);
        pv = v; pd = d; hc = HW'(h); vc = VW'(vv);
    endtask

    task automatic quiet(input int n);
        repeat (n) drive(0, '0, 1, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; pv = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int c = 0;
        quiet(2);
        while (busy !== 1'b0 && c < budget) begin
            quiet(1);
            c++;
        end
        check("wait_idle_busy", busy, 1'b0);
        quiet(3);
    endtask

    initial begin
        #800000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    int saved_rises;

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_sel",  csel,  1'b1);
        check("rst_clk",  cclk,  1'b0);
        check("rst_data", cdata, '0);
        check("rst_busy", busy,  1'b0);
        check("rst_ovf",  ovf,   1'b0);

        // Six pixels at even coordinates form one packet.
        clear_mon();
        for (int i = 1; i <= 6; i++) drive(1, DW'(i), 2 * i, 2);
        wait_idle(400);
        check("s1_npkt",   got_q.size(), 1);
        check("s1_line0",  got_word(0, 0), 16'h0001);
        check("s1_line5",  got_word(0, 5), 16'h0006);
        check("s1_cs_low", (low_q.size() > 0) ? low_q[0] : -1, 96);

        // Odd coordinates are never selected.
        clear_mon();
        for (int i = 0; i < 24; i++) drive(1, DW'(i + 16'h100), (i % 2 == 0) ? 2 * i + 1 : 2 * i, (i % 2 == 0) ? 2 : 3);
        quiet(20);
        check("s2_npkt", got_q.size(), 0);
        check("s2_busy_cycles", busy_cycles, 0);

        // A frame start discards the partial packet.
        clear_mon();
        for (int i = 0; i < 3; i++) drive(1, DW'(16'h00A1 + i), 2 * i + 2, 2);
        drive(1, 16'h00B0, 0, 0);
        for (int i = 0; i < 5; i++) drive(1, DW'(16'h00C1 + i), 2 * i + 2, 0);
        wait_idle(600);
`ifdef SPI_FRAME_MARKER_EN
        check("s3_npkt",   got_q.size(), 2);
        check("s3_marker", got_word(0, 3), 16'hFFFF);
        check("s3_slot0",  got_word(1, 0), 16'h00B0);
        check("s3_slot5",  got_word(1, 5), 16'h00C5);
`else
        check("s3_npkt",  got_q.size(), 1);
        check("s3_slot0", got_word(0, 0), 16'h00B0);
        check("s3_slot5", got_word(0, 5), 16'h00C5);
`endif

        // Six back-to-back packets overrun a four-deep FIFO once.
        clear_mon();
        for (int i = 0; i < 36; i++) drive(1, DW'(i + 1), 2 * i, 4);
        wait_idle(1200);
        check("s4_ovf_pulses", ovf_pulses, 1);
        check("s4_npkt",       got_q.size(), 5);
        check("s4_p4_slot0",   got_word(4, 0), 16'd25);
        check("s4_p0_slot5",   got_word(0, 5), 16'd6);

        // Reset in the middle of bit 7 aborts the transfer.
        clear_mon();
        saved_rises = ck_rises;
        for (int i = 0; i < 6; i++) drive(1, DW'(16'h5A00 + i), 2 * i + 2, 6);
        for (int c = 0; c < 200 && ck_rises < saved_rises + 7; c++) quiet(1);
        check("s5_reached_bit7", ck_rises - saved_rises, 7);
        quiet(4);
        do_reset();
        check("s5_sel_after_rst", csel, 1'b1);
        saved_rises = ck_rises;
        quiet(200);
        check("s5_no_clk_edges", ck_rises, saved_rises);
        check("s5_npkt", got_q.size(), 0);

`ifdef SPI_FRAME_MARKER_EN
        clear_mon();
        drive(1, 16'h0F00, 0, 0);
        for (int i = 1; i < 6; i++) drive(1, DW'(16'h0F00 + i), 2 * i, 0);
        wait_idle(600);
        check("s6_npkt",   got_q.size(), 2);
        check("s6_marker", got_word(0, 0), 16'hFFFF);
        check("s6_data0",  got_word(1, 0), 16'h0F00);
`endif

        // Randomized traffic: bursts, idle stretches, frame starts and rare resets.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 999) == 0);
            if ((c / 500) % 2 == 0) pv = ($urandom_range(0, 3) != 0);
            else                    pv = ($urandom_range(0, 15) == 0);
            pd = DW'($urandom);
            hc = HW'($urandom_range(0, 9));
            vc = VW'($urandom_range(0, 3));
        end
        @(negedge clk);
        rst = 1'b0;
        wait_idle(1500);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
